axi_rd_burst_engine: RTL and testbench
======================================

Name: axi_rd_burst_engine

Overview:
- AXI-4 read initiator: accepts a single read command (start address, beat count) and splits it into INCR bursts.
- Issues the bursts on AR, collects R beats, and returns them as a ready/valid data stream with a command-level last flag.
- Sits directly upstream of the AXI register-layer stage: its t_AXI4 initiator port drives that stage's responder side, which in turn reaches the NAP/DDR.

Parameters:
DATA_WIDTH, 512, AXI data width in bits; beat size in bytes is DATA_WIDTH/8.
ADDR_WIDTH, 42, AXI address width.
LEN_WIDTH, 8, AXI arlen width.
ID_WIDTH, 8, AXI id width.
CMD_LEN_WIDTH, 16, width of the command beat count.
MAX_BURST, 16, maximum beats per burst (1..256).
MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts (1..15).

Ports:
i_clk  input  1  clock
i_reset_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command ready; high only in IDLE
i_cmd_addr  input  ADDR_WIDTH  start byte address, beat-aligned
i_cmd_beats  input  CMD_LEN_WIDTH  total beats to read; 0 is legal
o_data_valid  output  1  read data valid
i_data_ready  input  1  read data ready
o_data  output  DATA_WIDTH  read data
o_data_last  output  1  final beat of the whole command
o_busy  output  1  command in progress
o_err  output  1  sticky: some rresp != OKAY since last command accept
o_perf_cycles  output  32  see Optional Feature
axi_if  t_AXI4.initiator  -  AXI-4 initiator

Behaviour:
Clock, reset and tie-offs:
- Single clock i_clk; reset i_reset_n is asynchronous, active-low.
- Reset values: o_cmd_ready=1, o_busy=0, o_err=0, arvalid=0, o_perf_cycles=0. Internal state: IDLE, outstanding=0, beat counters=0.
- Write channels tied off: awvalid=0, wvalid=0, bready=1.
- AR constants: arid=0, arburst=INCR, arsize=log2(DATA_WIDTH/8), arcache=4'b0011, arprot=0, arqos=0, arlock=0, arregion=0.

States:
- IDLE: command accepted on i_cmd_valid & o_cmd_ready. Captures addr/beats, clears o_err. Beats=0 -> stay IDLE, no AR, no data. Beats>0 -> ISSUE.
- ISSUE: drives AR while ar_remaining>0 and outstanding<MAX_OUTSTANDING. When ar_remaining reaches 0 -> DRAIN.
- DRAIN: waits until rx_remaining=0 -> IDLE.
- o_busy=1 in ISSUE and DRAIN.

Burst length:
- len = min(ar_remaining, MAX_BURST, beats to next 4 KB boundary); arlen = len-1.
- Beats to boundary = (4096 - addr[11:0]) / (DATA_WIDTH/8).
- arvalid is registered. Once asserted, arvalid and araddr/arlen hold stable until arready.
- On AR handshake: addr += len*(DATA_WIDTH/8); ar_remaining -= len; outstanding++.
- Next AR may be asserted the cycle after the handshake (at most one AR per 2 cycles).

R path:
- Combinational pass-through: o_data_valid=rvalid, rready=i_data_ready, o_data=rdata.
- On R handshake: rx_remaining--. o_data_last=1 when rx_remaining==1 and valid. rlast handshake -> outstanding--.
- A simultaneous AR handshake and rlast handshake leaves outstanding unchanged.
- rresp != 2'b00 on any beat sets o_err. Data is still passed; no abort.
- R beats outside ISSUE/DRAIN are a protocol error: accepted (rready follows i_data_ready) and dropped by the counters.

Reset:
- Reset mid-operation returns to IDLE immediately and drops arvalid asynchronously.
- The downstream responder must be reset together with this block.

Optional Feature:
AXI_RD_BURST_PERF_EN
- Defined: o_perf_cycles clears on command accept and increments every cycle while o_busy=1. It saturates at 32'hFFFF_FFFF and holds its value in IDLE.
- Undefined: o_perf_cycles is tied to 0 and no counter logic is present.

Decomposition:
- Package axi_rd_burst_pkg holds:
  - state enum t_rd_state {IDLE, ISSUE, DRAIN}
  - AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, AXI_4K_BYTES=4096
  - a function for the 4 KB beats-to-boundary calculation
- One sub-module, axi_rd_burst_split: registered next-burst calculator. Inputs addr and ar_remaining; outputs len/arlen, updated one cycle after each AR handshake.

Test Plan:
1. addr=0x0, beats=40, MAX_BURST=16, DATA_WIDTH=512, responder always ready -> three ARs at 0x0/0x400/0x800 with arlen 15/15/7; 40 data beats; o_data_last only on beat 40; o_busy drops after it.
2. addr=0x0FC0, beats=3 -> AR 0x0FC0 arlen=0, then AR 0x1000 arlen=1; no burst crosses 4 KB.
3. beats=80, rvalid held low for 200 cycles -> exactly 4 AR handshakes, arvalid then stays low. Releasing R restores further ARs, with 5 ARs in total.
4. During data, i_data_ready low for 10 cycles -> rready low, o_data stable, no beat lost or duplicated (checked by incrementing data pattern).
5. beats=0 -> o_cmd_ready stays 1, no arvalid, no o_data_valid. Then rresp=SLVERR on beat 2 of a 4-beat cmd -> o_err=1 until next cmd accept.
6. i_reset_n asserted mid-ISSUE with arvalid=1 -> arvalid=0, o_busy=0, o_cmd_ready=1 without waiting for a clock edge. With AXI_RD_BURST_PERF_EN, a 40-beat cmd gives o_perf_cycles equal to the busy-cycle count.

Source files
------------

// File: rtl/axi_rd_burst_pkg.sv
// Shared types and constants for the AXI-4 read burst engine.
package axi_rd_burst_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} t_rd_state;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         AXI_4K_BYTES   = 4096;

    // Whole beats left before the next 4 KB page; addr_lo is beat-aligned so this is never 0.
    function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo,
                                                input int unsigned size_log2);
        logic [12:0] bytes_left;
        bytes_left = 13'(AXI_4K_BYTES) - {1'b0, addr_lo};
        return bytes_left >> size_log2;
    endfunction

endpackage

// File: rtl/t_AXI4.sv
// AXI-4 bundle with initiator/responder views; the write channels carry only handshakes.
interface t_AXI4 #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 42,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [LEN_WIDTH-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic [3:0]            arqos;
    logic                  arlock;
    logic [3:0]            arregion;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  awvalid;
    logic                  awready;
    logic                  wvalid;
    logic                  wready;
    logic                  bvalid;
    logic                  bready;

    modport initiator (
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos, arlock, arregion,
               arvalid, rready, awvalid, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bvalid
    );

    modport responder (
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arqos, arlock, arregion,
               arvalid, rready, awvalid, wvalid, bready,
        output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/axi_rd_burst_split.sv
// Registered next-burst length: min(remaining, MAX_BURST, beats to 4 KB), one cycle behind its inputs.
module axi_rd_burst_split
    import axi_rd_burst_pkg::*;
#(
    parameter int          LEN_WIDTH     = 8,
    parameter int          CMD_LEN_WIDTH = 16,
    parameter int          MAX_BURST     = 16,
    parameter int unsigned SIZE_LOG2     = 6
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [11:0]              i_addr_lo,
    input  logic [CMD_LEN_WIDTH-1:0] i_ar_remaining,
    output logic [LEN_WIDTH:0]       o_len,
    output logic [LEN_WIDTH-1:0]     o_arlen
);

    logic [CMD_LEN_WIDTH-1:0] len_c;
    logic [LEN_WIDTH:0]       len_d, len_q;
    logic [LEN_WIDTH-1:0]     arlen_q;

    always_comb begin
        len_c = i_ar_remaining;
        if (len_c > CMD_LEN_WIDTH'(MAX_BURST))
            len_c = CMD_LEN_WIDTH'(MAX_BURST);
        if (len_c > CMD_LEN_WIDTH'(beats_to_4k(i_addr_lo, SIZE_LOG2)))
            len_c = CMD_LEN_WIDTH'(beats_to_4k(i_addr_lo, SIZE_LOG2));
        len_d = (LEN_WIDTH+1)'(len_c);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q   <= '0;
            arlen_q <= '0;
        end else begin
            len_q   <= len_d;
            arlen_q <= LEN_WIDTH'(len_d - 1'b1);
        end
    end

    assign o_len   = len_q;
    assign o_arlen = arlen_q;

endmodule

// File: rtl/axi_rd_burst_engine.sv
// AXI-4 read initiator: splits one command into 4 KB-safe INCR bursts and streams the R data out.
// Optional busy-cycle counter on o_perf_cycles when AXI_RD_BURST_PERF_EN is defined.
module axi_rd_burst_engine
    import axi_rd_burst_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 42,
    parameter int LEN_WIDTH       = 8,
    parameter int ID_WIDTH        = 8,
    parameter int CMD_LEN_WIDTH   = 16,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    i_cmd_addr,
    input  logic [CMD_LEN_WIDTH-1:0] i_cmd_beats,
    output logic                     o_data_valid,
    input  logic                     i_data_ready,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic                     o_data_last,
    output logic                     o_busy,
    output logic                     o_err,
    output logic [31:0]              o_perf_cycles,
    t_AXI4.initiator                 axi_if
);

    localparam int unsigned SIZE_LOG2 = $clog2(DATA_WIDTH/8);

    t_rd_state                state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [CMD_LEN_WIDTH-1:0] ar_rem_q, ar_rem_d, rx_rem_q, rx_rem_d;
    logic [3:0]               outst_q, outst_d;
    logic                     arvalid_q, arvalid_d, err_q, err_d;
    logic [LEN_WIDTH:0]       len;
    logic [LEN_WIDTH-1:0]     arlen;
    logic                     busy, cmd_acc, ar_hs, r_hs, rlast_hs;

    assign busy     = (state_q != IDLE);
    assign cmd_acc  = i_cmd_valid && (state_q == IDLE);
    assign ar_hs    = arvalid_q && axi_if.arready;
    assign r_hs     = axi_if.rvalid && i_data_ready;
    assign rlast_hs = r_hs && axi_if.rlast && busy;

    axi_rd_burst_split #(
        .LEN_WIDTH     (LEN_WIDTH),
        .CMD_LEN_WIDTH (CMD_LEN_WIDTH),
        .MAX_BURST     (MAX_BURST),
        .SIZE_LOG2     (SIZE_LOG2)
    ) u_split (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_addr_lo      (addr_q[11:0]),
        .i_ar_remaining (ar_rem_q),
        .o_len          (len),
        .o_arlen        (arlen)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ar_rem_d  = ar_rem_q;
        rx_rem_d  = rx_rem_q;
        outst_d   = outst_q;
        arvalid_d = arvalid_q;
        err_d     = err_q;

        case ({ar_hs, rlast_hs})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
        // Stray beats outside a command still pass through but never touch the counters.
        if (r_hs && busy && rx_rem_q != '0)
            rx_rem_d = rx_rem_q - 1'b1;
        if (r_hs && axi_if.rresp != AXI_RESP_OKAY)
            err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    addr_d   = i_cmd_addr;
                    ar_rem_d = i_cmd_beats;
                    rx_rem_d = i_cmd_beats;
                    outst_d  = '0;
                    err_d    = 1'b0;
                    if (i_cmd_beats != '0)
                        state_d = ISSUE;
                end
            end
            ISSUE: begin
                // arvalid rises the cycle after the split block has caught up with addr/remaining.
                if (ar_hs) begin
                    addr_d    = addr_q + (ADDR_WIDTH'(len) << SIZE_LOG2);
                    ar_rem_d  = ar_rem_q - CMD_LEN_WIDTH'(len);
                    arvalid_d = 1'b0;
                    if (ar_rem_d == '0)
                        state_d = DRAIN;
                end else if (!arvalid_q && ar_rem_q != '0 && outst_q < 4'(MAX_OUTSTANDING)) begin
                    arvalid_d = 1'b1;
                end
            end
            DRAIN: begin
                if (rx_rem_q == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            ar_rem_q  <= '0;
            rx_rem_q  <= '0;
            outst_q   <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ar_rem_q  <= ar_rem_d;
            rx_rem_q  <= rx_rem_d;
            outst_q   <= outst_d;
            arvalid_q <= arvalid_d;
            err_q     <= err_d;
        end
    end

`ifdef AXI_RD_BURST_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (cmd_acc)
            perf_d = '0;
        else if (busy && perf_q != '1)
            perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) perf_q <= '0;
        else            perf_q <= perf_d;
    end

    assign o_perf_cycles = perf_q;
`else
    assign o_perf_cycles = '0;
`endif

    assign o_cmd_ready  = (state_q == IDLE);
    assign o_busy       = busy;
    assign o_err        = err_q;
    assign o_data_valid = axi_if.rvalid;
    assign o_data       = axi_if.rdata;
    assign o_data_last  = axi_if.rvalid && busy && (rx_rem_q == CMD_LEN_WIDTH'(1));

    assign axi_if.arvalid  = arvalid_q;
    assign axi_if.araddr   = addr_q;
    assign axi_if.arlen    = arlen;
    assign axi_if.arid     = '0;
    assign axi_if.arsize   = 3'(SIZE_LOG2);
    assign axi_if.arburst  = AXI_BURST_INCR;
    assign axi_if.arcache  = 4'b0011;
    assign axi_if.arprot   = '0;
    assign axi_if.arqos    = '0;
    assign axi_if.arlock   = 1'b0;
    assign axi_if.arregion = '0;
    assign axi_if.rready   = i_data_ready;
    assign axi_if.awvalid  = 1'b0;
    assign axi_if.wvalid   = 1'b0;
    assign axi_if.bready   = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{axi_if.rid, axi_if.awready, axi_if.wready, axi_if.bvalid};

endmodule

// File: tb/tb_axi_rd_burst_engine.sv
// Scoreboard bench for axi_rd_burst_engine with a behavioural AXI read responder.
module tb_axi_rd_burst_engine;

    typedef struct { logic [41:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [511:0] d; logic last; } dt_t;

    logic         i_clk = 1'b0;
    logic         i_reset_n, i_cmd_valid, o_cmd_ready, o_data_valid, i_data_ready;
    logic [41:0]  i_cmd_addr;
    logic [15:0]  i_cmd_beats;
    logic [511:0] o_data;
    logic         o_data_last, o_busy, o_err;
    logic [31:0]  o_perf_cycles;

    t_AXI4 #(.DATA_WIDTH(512), .ADDR_WIDTH(42), .LEN_WIDTH(8), .ID_WIDTH(8)) axi ();

    axi_rd_burst_engine dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr), .i_cmd_beats(i_cmd_beats), .o_data_valid(o_data_valid),
        .i_data_ready(i_data_ready), .o_data(o_data), .o_data_last(o_data_last), .o_busy(o_busy),
        .o_err(o_err), .o_perf_cycles(o_perf_cycles), .axi_if(axi)
    );

    always #5 i_clk = ~i_clk;

    int  checks = 0, errors = 0;
    ar_t ar_exp[$];
    dt_t data_exp[$];
    ar_t bq[$];
    int  bi = 0, ar_cnt = 0, r_cnt = 0, busy_cnt = 0, err_at = -1;
    bit  err_seen = 0, ar_block = 0, r_block = 0, ar_rand = 0, r_rand = 0, rand_err = 0;

    function automatic logic [511:0] pat(input logic [41:0] a);
        logic [63:0] w;
        w = {22'h0, a} ^ 64'hC3A5_0F1E_0000_0000;
        return {8{w}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor + responder: checks at negedge, drives responder outputs just after posedge.
    initial begin
        logic        r_took, arv_hold, r_hold;
        logic [41:0] p_addr;
        logic [7:0]  p_len;
        logic [511:0] p_data;
        ar_t         e;
        dt_t         de;
        arv_hold = 0; r_hold = 0; r_took = 0; p_addr = '0; p_len = '0; p_data = '0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 0; axi.rlast = 0;
        axi.rid = '0; axi.awready = 1; axi.wready = 1; axi.bvalid = 0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                ar_exp.delete(); data_exp.delete(); bq.delete();
                bi = 0; arv_hold = 0; r_hold = 0; r_took = 0;
                axi.arready = 0; axi.rvalid = 0;
                continue;
            end
            if (i_cmd_valid && o_cmd_ready) begin busy_cnt = 0; err_seen = 0; end
            else if (o_busy) busy_cnt++;
            chk("rready_pass", axi.rready, i_data_ready);
            if (arv_hold) chk("ar_stable", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, p_addr, p_len});
            if (axi.arvalid && axi.arready) begin
                chk("outstanding_limit", bq.size() < 4, 1'b1);
                if (ar_exp.size() == 0) chk("ar_unexpected", axi.arvalid, 1'b0);
                else begin
                    e = ar_exp.pop_front();
                    chk("ar_addr_len", {axi.araddr, axi.arlen}, {e.addr, e.len});
                end
                chk("ar_const", {axi.arid, axi.arsize, axi.arburst, axi.arcache, axi.arprot,
                                 axi.arqos, axi.arlock, axi.arregion},
                                {8'h0, 3'd6, 2'b01, 4'b0011, 3'd0, 4'd0, 1'b0, 4'd0});
                bq.push_back('{axi.araddr, axi.arlen});
                ar_cnt++;
            end
            arv_hold = axi.arvalid && !axi.arready;
            p_addr = axi.araddr; p_len = axi.arlen;
            if (r_hold) chk("r_stable", {o_data_valid, o_data}, {1'b1, p_data});
            r_took = o_data_valid && i_data_ready;
            if (r_took) begin
                if (axi.rresp != 2'b00) err_seen = 1;
                if (data_exp.size() == 0) chk("data_unexpected", o_data_valid, 1'b0);
                else begin
                    de = data_exp.pop_front();
                    chk("data", o_data, de.d);
                    chk("data_last", o_data_last, de.last);
                end
                bi++;
                if (axi.rlast && bq.size() > 0) begin void'(bq.pop_front()); bi = 0; end
                r_cnt++;
            end
            r_hold = o_data_valid && !i_data_ready;
            p_data = o_data;

            @(posedge i_clk); #1;
            if (!i_reset_n) begin
                axi.arready = 0; axi.rvalid = 0;
            end else begin
                axi.arready = ar_block ? 1'b0 : (ar_rand ? 1'($urandom % 2) : 1'b1);
                if (!(axi.rvalid && !r_took)) begin
                    if (!r_block && bq.size() > 0 && (!r_rand || ($urandom % 4) != 0)) begin
                        axi.rvalid = 1;
                        axi.rdata  = pat(bq[0].addr + 42'(bi * 64));
                        axi.rlast  = (bi == int'(bq[0].len));
                        axi.rresp  = (r_cnt == err_at || (rand_err && ($urandom % 16) == 0)) ? 2'b10 : 2'b00;
                    end else begin
                        axi.rvalid = 0;
                    end
                end
            end
        end
    end

    // Reference: split by remaining beats, MAX_BURST=16 and 64-byte beats within a 4 KB page.
    task automatic issue(input logic [41:0] a, input int n);
        longint ad;
        int rem, l, b2b, t;
        @(posedge i_clk); #1;
        t = 0;
        while (!o_cmd_ready) begin
            if (t++ > 1000) begin
                checks++; errors++; $display("FAIL cmd_ready_timeout: got 0 expected 1");
                break;
            end
            @(posedge i_clk); #1;
        end
        ad = longint'(a); rem = n;
        while (rem > 0) begin
            b2b = int'((4096 - (ad % 4096)) / 64);
            l = rem;
            if (l > 16) l = 16;
            if (l > b2b) l = b2b;
            ar_exp.push_back('{42'(ad), 8'(l - 1)});
            ad += longint'(l) * 64;
            rem -= l;
        end
        for (int k = 0; k < n; k++) data_exp.push_back('{pat(a + 42'(k * 64)), k == n - 1});
        i_cmd_valid = 1; i_cmd_addr = a; i_cmd_beats = 16'(n);
        @(posedge i_clk); #1;
        i_cmd_valid = 0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int t;
        t = 0;
        forever begin
            @(negedge i_clk);
            if (ar_exp.size() == 0 && data_exp.size() == 0 && !o_busy) break;
            if (t >= budget) begin
                checks++; errors++;
                $display("FAIL done_timeout: got busy=%0b ar_left=%0d data_left=%0d expected idle",
                         o_busy, ar_exp.size(), data_exp.size());
                break;
            end
            t++;
            @(posedge i_clk); #1;
            if (rnd) i_data_ready = ($urandom % 3) != 0;
        end
        i_data_ready = 1;
    endtask

    initial begin
        int a0;
        i_reset_n = 0; i_cmd_valid = 0; i_cmd_addr = '0; i_cmd_beats = '0; i_data_ready = 1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cmd_ready", o_cmd_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_err", o_err, 1'b0);
        chk("rst_arvalid", axi.arvalid, 1'b0);
        chk("rst_perf", o_perf_cycles, 32'd0);
        chk("tieoffs", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        @(posedge i_clk); #1; i_reset_n = 1;

        // 40 beats from 0: 16/16/8
        a0 = ar_cnt;
        issue(42'h0, 40);
        wait_done(0, 2000);
        chk("t1_ar_count", ar_cnt - a0, 3);
        @(negedge i_clk);
        chk("t1_cmd_ready", o_cmd_ready, 1'b1);
`ifdef AXI_RD_BURST_PERF_EN
        chk("perf_cycles", o_perf_cycles, 32'(busy_cnt));
`else
        chk("perf_tied", o_perf_cycles, 32'd0);
`endif

        // 4 KB boundary split
        a0 = ar_cnt;
        issue(42'h0FC0, 3);
        wait_done(0, 500);
        chk("t2_ar_count", ar_cnt - a0, 2);

        // Outstanding limit with R stalled
        a0 = ar_cnt;
        r_block = 1;
        issue(42'h0, 80);
        repeat (200) @(posedge i_clk);
        @(negedge i_clk);
        chk("t3_ar_stalled", ar_cnt - a0, 4);
        chk("t3_arvalid_low", axi.arvalid, 1'b0);
        @(posedge i_clk); #1; r_block = 0;
        wait_done(0, 2000);
        chk("t3_ar_total", ar_cnt - a0, 5);

        // Backpressure for 10 cycles mid-stream
        issue(42'h10000, 40);
        repeat (8) begin @(posedge i_clk); #1; end
        i_data_ready = 0;
        repeat (10) begin
            @(negedge i_clk);
            chk("t4_rready_low", axi.rready, 1'b0);
            @(posedge i_clk); #1;
        end
        i_data_ready = 1;
        wait_done(0, 2000);

        // Zero-beat command
        issue(42'h40, 0);
        repeat (5) begin
            @(negedge i_clk);
            chk("t5_zero_ready", o_cmd_ready, 1'b1);
            chk("t5_zero_arvalid", axi.arvalid, 1'b0);
            chk("t5_zero_dvalid", o_data_valid, 1'b0);
            @(posedge i_clk); #1;
        end

        // SLVERR on beat 2 of 4
        err_at = r_cnt + 1;
        issue(42'h2000, 4);
        wait_done(0, 500);
        err_at = -1;
        chk("t5_err_set", o_err, 1'b1);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("t5_err_sticky", o_err, 1'b1);
        issue(42'h0, 0);
        @(negedge i_clk);
        chk("t5_err_cleared", o_err, 1'b0);

        // Randomized commands
        ar_rand = 1; r_rand = 1; rand_err = 1;
        for (int i = 0; i < 15; i++) begin
            issue(42'(4096 * $urandom_range(0, 15) + 64 * $urandom_range(0, 63)), $urandom_range(0, 70));
            wait_done(1, 4000);
            chk("rand_err", o_err, err_seen);
        end
        ar_rand = 0; r_rand = 0; rand_err = 0;

        // Asynchronous reset with arvalid pending
        ar_block = 1;
        issue(42'h3000, 40);
        begin
            int t;
            t = 0;
            while (!axi.arvalid && t < 50) begin @(negedge i_clk); t++; end
            chk("t6_arvalid_up", axi.arvalid, 1'b1);
        end
        @(negedge i_clk); #2;
        i_reset_n = 0;
        #1;
        chk("t6_async_arvalid", axi.arvalid, 1'b0);
        chk("t6_async_busy", o_busy, 1'b0);
        chk("t6_async_ready", o_cmd_ready, 1'b1);
        repeat (3) @(posedge i_clk);
        #1; ar_block = 0; i_reset_n = 1;
        issue(42'h3F80, 20);
        wait_done(0, 2000);
        @(negedge i_clk);
        chk("t6_recovered", {o_busy, o_cmd_ready}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
